// File: rtl/cache_dm_wt_sync.sv
// cache_dm_wt_sync
// -----------------------------------------------------------------------------
// Direct-mapped, write-through / write-allocate data cache with a byte-wide CPU
// port and a block-wide memory port. Both ports use a req/ready handshake.
// Memory latency may vary.
//
// Lines are never dirty, so a conflicting miss simply overwrites the line.
// Every store, hit or miss, is sent to memory as a full block.
//
// Ports
//   clk, rst_n           rising-edge clock, asynchronous active-low reset
//   cpu_req/we/addr/wdata CPU request. It is sampled only in IDLE.
//   cpu_rdata/ready/hit   Registered one-cycle completion (RESP state).
//   mem_req/we/addr/wdata Registered memory request. It is held until mem_ready.
//   mem_rdata/ready       Fill data and completion strobe from memory.
//   hit_cnt/miss_cnt      Saturating statistics counters. These ports exist
//                         only when the macro CACHE_STATS_EN is defined.
//
// Byte layout is big-endian. Byte 0 of the block occupies the block MSBs.
// -----------------------------------------------------------------------------
module cache_dm_wt_sync #(
    parameter int ADDR_W = 10,
    parameter int LINES  = 4,
    parameter int WORDS  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_W-1:0]     cpu_addr,
    input  logic [7:0]            cpu_wdata,
    output logic [7:0]            cpu_rdata,
    output logic                  cpu_ready,
    output logic                  cpu_hit,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [32*WORDS-1:0]   mem_wdata,
    input  logic [32*WORDS-1:0]   mem_rdata,
    input  logic                  mem_ready
`ifdef CACHE_STATS_EN
    ,
    output logic [15:0]           hit_cnt,
    output logic [15:0]           miss_cnt
`endif
);

    localparam int BLK_W = 32 * WORDS;
    localparam int OFF_W = $clog2(4 * WORDS);
    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = ADDR_W - IDX_W - OFF_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        WTHRU = 2'd2,
        RESP  = 2'd3
    } state_t;

    // The number of bytes per block is a power of two. Because of that,
    // the distance of byte 'off' from the LSB end is simply ~off.
    function automatic logic [7:0] get_byte(input logic [BLK_W-1:0] blk,
                                            input logic [OFF_W-1:0] off);
        logic [BLK_W-1:0] sh;
        sh = blk >> {~off, 3'b000};
        return sh[7:0];
    endfunction

    function automatic logic [BLK_W-1:0] put_byte(input logic [BLK_W-1:0] blk,
                                                  input logic [OFF_W-1:0] off,
                                                  input logic [7:0]       b);
        logic [BLK_W-1:0] mask;
        logic [BLK_W-1:0] data;
        mask = {{(BLK_W-8){1'b0}}, 8'hFF} << {~off, 3'b000};
        data = {{(BLK_W-8){1'b0}}, b} << {~off, 3'b000};
        return (blk & ~mask) | data;
    endfunction

    state_t             state_r;
    state_t             state_s;
    logic               accept_s;
    logic               fill_done_s;
    logic               wt_done_s;

    // Request fields latched at accept
    logic               we_r;
    logic [ADDR_W-1:0]  addr_r;
    logic [7:0]         wdata_r;
    logic               hit_r;

    // Cache storage. Only valid is reset.
    logic [LINES-1:0]   valid_r;
    logic [TAG_W-1:0]   tag_mem [LINES];
    logic [BLK_W-1:0]   data_mem [LINES];

    // Lookup on the live CPU address. This is used only in IDLE.
    logic [TAG_W-1:0]   lk_tag_s;
    logic [IDX_W-1:0]   lk_idx_s;
    logic [OFF_W-1:0]   lk_off_s;
    logic               lk_hit_s;
    logic [BLK_W-1:0]   lk_line_s;
    logic [BLK_W-1:0]   merged_hit_s;

    // Fields of the latched request. These are used in FILL and WTHRU.
    logic [TAG_W-1:0]   rq_tag_s;
    logic [IDX_W-1:0]   rq_idx_s;
    logic [OFF_W-1:0]   rq_off_s;
    logic [BLK_W-1:0]   merged_fill_s;

    assign lk_tag_s     = cpu_addr[ADDR_W-1 -: TAG_W];
    assign lk_idx_s     = cpu_addr[OFF_W +: IDX_W];
    assign lk_off_s     = cpu_addr[OFF_W-1:0];
    assign lk_line_s    = data_mem[lk_idx_s];
    assign lk_hit_s     = valid_r[lk_idx_s] && (tag_mem[lk_idx_s] == lk_tag_s);
    assign merged_hit_s = put_byte(lk_line_s, lk_off_s, cpu_wdata);

    assign rq_tag_s      = addr_r[ADDR_W-1 -: TAG_W];
    assign rq_idx_s      = addr_r[OFF_W +: IDX_W];
    assign rq_off_s      = addr_r[OFF_W-1:0];
    assign merged_fill_s = put_byte(mem_rdata, rq_off_s, wdata_r);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic and transaction strobes
    always_comb begin
        state_s     = state_r;
        accept_s    = 1'b0;
        fill_done_s = 1'b0;
        wt_done_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (cpu_req) begin
                    accept_s = 1'b1;
                    if (lk_hit_s && !cpu_we) begin
                        state_s = RESP;
                    end else if (lk_hit_s) begin
                        state_s = WTHRU;
                    end else begin
                        state_s = FILL;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            FILL: begin
                if (mem_ready) begin
                    fill_done_s = 1'b1;
                    state_s     = we_r ? WTHRU : RESP;
                end else begin
                    state_s = FILL;
                end
            end
            WTHRU: begin
                if (mem_ready) begin
                    wt_done_s = 1'b1;
                    state_s   = RESP;
                end else begin
                    state_s = WTHRU;
                end
            end
            RESP: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Registered outputs and latched request fields
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cpu_ready <= 1'b0;
            cpu_hit   <= 1'b0;
            cpu_rdata <= 8'h00;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= {ADDR_W{1'b0}};
            mem_wdata <= {BLK_W{1'b0}};
            we_r      <= 1'b0;
            addr_r    <= {ADDR_W{1'b0}};
            wdata_r   <= 8'h00;
            hit_r     <= 1'b0;
        end else begin
            // The response is a one-cycle pulse unless it is re-armed below.
            cpu_ready <= 1'b0;
            cpu_hit   <= 1'b0;
            cpu_rdata <= 8'h00;
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        we_r    <= cpu_we;
                        addr_r  <= cpu_addr;
                        wdata_r <= cpu_wdata;
                        hit_r   <= lk_hit_s;
                        if (lk_hit_s && !cpu_we) begin
                            cpu_ready <= 1'b1;
                            cpu_hit   <= 1'b1;
                            cpu_rdata <= get_byte(lk_line_s, lk_off_s);
                        end else if (lk_hit_s) begin
                            mem_req   <= 1'b1;
                            mem_we    <= 1'b1;
                            mem_addr  <= {cpu_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                            mem_wdata <= merged_hit_s;
                        end else begin
                            mem_req   <= 1'b1;
                            mem_we    <= 1'b0;
                            mem_addr  <= {cpu_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                        end
                    end
                end
                FILL: begin
                    if (fill_done_s) begin
                        if (we_r) begin
                            // The request stays up and turns into the write-through
                            // of the merged block at the same address.
                            mem_we    <= 1'b1;
                            mem_wdata <= merged_fill_s;
                        end else begin
                            mem_req   <= 1'b0;
                            cpu_ready <= 1'b1;
                            cpu_hit   <= hit_r;
                            cpu_rdata <= get_byte(mem_rdata, rq_off_s);
                        end
                    end
                end
                WTHRU: begin
                    if (wt_done_s) begin
                        mem_req   <= 1'b0;
                        mem_we    <= 1'b0;
                        cpu_ready <= 1'b1;
                        cpu_hit   <= hit_r;
                    end
                end
                RESP: begin
                    mem_req <= 1'b0;
                end
                default: begin
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

    // Valid bits, which are the only reset part of the storage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r <= {LINES{1'b0}};
        end else if (fill_done_s) begin
            valid_r[rq_idx_s] <= 1'b1;
        end
    end

    // Data and tag arrays. These are not reset, and valid qualifies them.
    always_ff @(posedge clk) begin
        if (accept_s && lk_hit_s && cpu_we) begin
            data_mem[lk_idx_s] <= merged_hit_s;
        end else if (fill_done_s) begin
            data_mem[rq_idx_s] <= we_r ? merged_fill_s : mem_rdata;
            tag_mem[rq_idx_s]  <= rq_tag_s;
        end
    end

`ifdef CACHE_STATS_EN
    logic resp_hit_s;
    logic resp_go_s;

    // A read hit reaches RESP straight from IDLE and has not latched hit_r yet.
    assign resp_hit_s = (state_r == IDLE) ? lk_hit_s : hit_r;
    assign resp_go_s  = (state_s == RESP) && (state_r != RESP);

    // Saturating hit/miss counters. They update together with cpu_ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_cnt  <= 16'h0000;
            miss_cnt <= 16'h0000;
        end else if (resp_go_s) begin
            if (resp_hit_s) begin
                if (hit_cnt != 16'hFFFF) begin
                    hit_cnt <= hit_cnt + 16'h0001;
                end
            end else begin
                if (miss_cnt != 16'hFFFF) begin
                    miss_cnt <= miss_cnt + 16'h0001;
                end
            end
        end
    end
`endif

endmodule

// File: doc/cache_dm_wt_sync.md
Name: cache_dm_wt_sync

Overview:
- Parametrised, clocked successor of the team's direct-mapped write-through data cache.
- Byte-wide CPU port with a req/ready handshake.
- Block-wide memory port with a req/ready handshake; memory latency is variable.
- Policy: write-through, write-allocate. Sits between the CPU datapath and main memory; every store is propagated to memory as a whole block.

Parameters:
- ADDR_W, 10, byte-address width.
- LINES, 4, number of cache lines; power of 2, ≥2.
- WORDS, 4, 32-bit words per block; power of 2, ≥1.
- Derived (localparams):
  - BLK_W = 32*WORDS
  - OFF_W = log2(4*WORDS)
  - IDX_W = log2(LINES)
  - TAG_W = ADDR_W-IDX_W-OFF_W, must be ≥1

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- cpu_req  in  1  CPU request; held until cpu_ready
- cpu_we  in  1  0=read, 1=write
- cpu_addr  in  ADDR_W  byte address
- cpu_wdata  in  8  store byte
- cpu_rdata  out  8  load byte; valid while cpu_ready=1
- cpu_ready  out  1  one-cycle completion pulse
- cpu_hit  out  1  hit/miss result of the completing request; valid with cpu_ready
- mem_req  out  1  memory request; held until mem_ready
- mem_we  out  1  0=block fill, 1=block write-through
- mem_addr  out  ADDR_W  block-aligned address (offset bits 0)
- mem_wdata  out  BLK_W  block to write
- mem_rdata  in  BLK_W  fill data; sampled when mem_ready=1
- mem_ready  in  1  memory completion, one cycle

Behaviour:
- Address fields:
  - tag = cpu_addr[ADDR_W-1 -: TAG_W]
  - index = next IDX_W bits below the tag
  - offset = low OFF_W bits
- Big-endian layout: word 0 occupies block MSBs; byte 0 of a word occupies bits [31:24].
- Storage: data[LINES] of BLK_W bits, tag[LINES], valid[LINES]. Only valid is reset; data and tag arrays are not reset.
- Reset (async, rst_n=0):
  - valid all 0; state IDLE.
  - cpu_ready, cpu_hit, cpu_rdata, mem_req, mem_we, mem_addr, mem_wdata all 0.
- FSM states: IDLE, FILL, WTHRU, RESP.
  - IDLE: when cpu_req=1, latch we/addr/wdata and look up. cpu_req is ignored in every other state.
    - Read hit → RESP.
    - Read miss → FILL.
    - Write hit → merge byte into line → WTHRU.
    - Write miss → FILL.
  - FILL: mem_req=1, mem_we=0, mem_addr={tag,index,0}. On mem_ready:
    - line ← mem_rdata, tag written, valid=1.
    - Read → RESP.
    - Write → merge byte into line → WTHRU.
  - WTHRU: mem_req=1, mem_we=1, mem_addr={tag,index,0}, mem_wdata=merged line. On mem_ready → RESP.
  - RESP: cpu_ready=1 for exactly one cycle; cpu_rdata=selected byte (reads; 0 for writes); cpu_hit = lookup result from IDLE → IDLE.
- Latency, counting the accept edge as cycle 0:
  - Read hit: cpu_ready at cycle 1.
  - Read miss: cpu_ready 1 cycle after the mem_ready edge.
  - Write hit: 1 cycle after the WTHRU mem_ready.
  - Write miss: fill, then write-through, then RESP.
  - Minimum spacing between back-to-back requests: 2 cycles.
- Memory handshake:
  - mem_req, mem_we, mem_addr and mem_wdata are registered and stable while mem_req=1.
  - mem_req drops the cycle after mem_ready.
  - mem_ready while mem_req=0 is ignored.
- Conflict: a miss to a valid line with a different tag overwrites the line. No eviction write is needed, because the line is always clean.
- Reset mid-operation: outputs go to their reset values immediately (async), the transaction is abandoned, all lines are invalid, and no cpu_ready is issued.
- cpu_req may remain high across RESP. It is re-accepted on the next IDLE cycle as a new request.

Optional Feature:
- Macro CACHE_STATS_EN.
- Defined:
  - Adds outputs hit_cnt[15:0] and miss_cnt[15:0], reset to 0.
  - Exactly one counter increments per accepted request, in the cycle cpu_ready pulses, according to cpu_hit.
  - Counters saturate at 16'hFFFF.
- Undefined: neither the ports nor the counter logic exist; all other behaviour is identical.

Test Plan:
- Defaults, after reset, read 0x000:
  - Expect mem_req=1, mem_we=0, mem_addr=0x000.
  - Bench drives mem_ready 3 cycles later with mem_rdata=128'h00112233_44556677_8899AABB_CCDDEEFF.
  - Expect cpu_ready with cpu_rdata=0x00, cpu_hit=0.
  - Then read 0x005 → cpu_ready at cycle 1 after accept, cpu_rdata=0x55, cpu_hit=1, no mem_req.
- Write hit 0x006 data 0xA5:
  - Expect mem_we=1, mem_addr=0x000, mem_wdata=128'h00112233_4455A577_8899AABB_CCDDEEFF, then cpu_hit=1.
  - Read 0x006 → 0xA5, hit.
- Conflict:
  - Read 0x040 (index 0, tag 1) → miss with mem_addr=0x040.
  - Then read 0x000 → miss again with mem_addr=0x000.
- Write miss 0x0F3 data 0x3C on an invalid line:
  - Expect fill at mem_addr=0x0F0.
  - Then write-through of the fill block with bits [103:96] replaced by 0x3C; cpu_hit=0.
- Reset mid-operation: pull rst_n low during FILL with mem_req=1.
  - mem_req=0 with no clock edge.
  - After release, read 0x005 → miss.
- With CACHE_STATS_EN, run the first four scenarios → hit_cnt=3, miss_cnt=4.
